boot_sequencer: RTL and testbench

Synthesizable load-and-run controller for the rv32i_sc single-cycle core on the Zybo Z7-20. It accepts a valid/ready word stream and writes the data image into the data BRAM, then the program image into the instruction BRAM, through the BRAMs' write ports. It then releases the core for a programmed cycle budget, or until an early halt, and re-stalls it. Word counts, address width and run budget are parameters and runtime inputs, so the same block drives any test program without a simulation-only loader.

---
 rtl/boot_sequencer_pkg.sv | 34 +++
 rtl/boot_sequencer_word_addr_counter.sv | 47 ++++
 rtl/boot_sequencer.sv | 249 ++++++++++++++++++++++++
 tb/tb_boot_sequencer.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/boot_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// boot_sequencer_pkg
//
// Shared definitions for the boot sequencer: the state encoding (exported so
// benches and debug logic can decode the sequencer state), the default stream
// word width of the rv32i_sc core, and a small count-clamping helper.
//
// Contents:
//   BOOT_DATA_WIDTH  default stream / BRAM word width of the core
//   boot_state_t     3-bit state type
//   ST_*             state encodings
//   clamp_words()    saturate a requested word count to the BRAM capacity
// -----------------------------------------------------------------------------
package boot_sequencer_pkg;

  // Word width of the rv32i_sc data path.
  localparam int BOOT_DATA_WIDTH = 32;

  typedef logic [2:0] boot_state_t;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_LOAD_D = 3'd1;
  localparam logic [2:0] ST_LOAD_I = 3'd2;
  localparam logic [2:0] ST_RUN    = 3'd3;
  localparam logic [2:0] ST_DONE   = 3'd4;

  // Requested counts larger than the BRAM word capacity are saturated so the
  // load never wraps back over address 0.
  function automatic int unsigned clamp_words(input int unsigned count,
                                              input int unsigned cap);
    return (count > cap) ? cap : count;
  endfunction

endpackage

// File: rtl/boot_sequencer_word_addr_counter.sv
// -----------------------------------------------------------------------------
// word_addr_counter
//
// Word index shared by the data and instruction load phases. Produces the BRAM
// byte address of the current word and flags when the current word is the
// last one of the phase.
//
// Ports:
//   clk        system clock
//   rst        asynchronous active-low reset
//   clr        return the index to 0 (takes priority over inc)
//   inc        advance the index by one word
//   count      clamped number of words in the current phase (nonzero while used)
//   byte_addr  byte address of the current word (index << 2)
//   last       current index is the final word of the phase
// -----------------------------------------------------------------------------
module word_addr_counter #(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  inc,
  input  logic [ADDR_WIDTH-1:0] count,
  output logic [ADDR_WIDTH-1:0] byte_addr,
  output logic                  last
);

  localparam logic [ADDR_WIDTH-1:0] ONE = ADDR_WIDTH'(1);

  logic [ADDR_WIDTH-1:0] idx_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx_reg <= '0;
    end else if (clr) begin
      idx_reg <= '0;
    end else if (inc) begin
      idx_reg <= idx_reg + ONE;
    end
  end

  // The index never exceeds capacity-1, so the shifted address always fits.
  assign byte_addr = idx_reg << 2;
  assign last      = (idx_reg == (count - ONE));

endmodule

// File: rtl/boot_sequencer.sv
// -----------------------------------------------------------------------------
// boot_sequencer
//
// Load-and-run controller for the rv32i_sc core. Streams a data image into the
// data BRAM, then a program image into the instruction BRAM, releases the core
// for a programmed number of clocks (or until it requests a halt), and stalls
// it again with the register file still readable.
//
// Parameters:
//   DATA_WIDTH  stream and BRAM word width
//   ADDR_WIDTH  BRAM byte-address width (word capacity 2^(ADDR_WIDTH-2))
//   RUN_W       width of the run budget and run counter
//
// Ports:
//   clk, rst                  clock, asynchronous active-low reset
//   start                     begin a sequence (honoured in IDLE or DONE only)
//   d_count, i_count          data / instruction word counts, sampled at start
//   run_cycles                core run budget in clocks, sampled at start
//   s_valid, s_data, s_ready  word stream (data words first, then program)
//   halt                      early stop request from the core
//   d_w_addr/d_w_dat/d_w_enb  data BRAM write port
//   i_w_addr/i_w_dat/i_w_enb  instruction BRAM write port
//   d_bram_init_done          data BRAM write port handed to the core
//   pc_stall, i_r_enb, rd_enbl core control
//   busy, done, halted, cycles_run  status
// -----------------------------------------------------------------------------
module boot_sequencer
  import boot_sequencer_pkg::*;
#(
  parameter int DATA_WIDTH = BOOT_DATA_WIDTH,
  parameter int ADDR_WIDTH = 10,
  parameter int RUN_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] d_count,
  input  logic [ADDR_WIDTH-1:0] i_count,
  input  logic [RUN_W-1:0]      run_cycles,
  input  logic                  s_valid,
  input  logic [DATA_WIDTH-1:0] s_data,
  output logic                  s_ready,
  input  logic                  halt,
  output logic [ADDR_WIDTH-1:0] d_w_addr,
  output logic [DATA_WIDTH-1:0] d_w_dat,
  output logic                  d_w_enb,
  output logic [ADDR_WIDTH-1:0] i_w_addr,
  output logic [DATA_WIDTH-1:0] i_w_dat,
  output logic                  i_w_enb,
  output logic                  d_bram_init_done,
  output logic                  pc_stall,
  output logic                  i_r_enb,
  output logic                  rd_enbl,
  output logic                  busy,
  output logic                  done,
  output logic                  halted,
  output logic [RUN_W-1:0]      cycles_run
);

  localparam logic [ADDR_WIDTH-1:0] WORD_CAP = ADDR_WIDTH'(1) << (ADDR_WIDTH - 2);

  boot_state_t state_reg;
  boot_state_t state_next;

  // Per-sequence parameters captured at start.
  logic [ADDR_WIDTH-1:0] d_cnt_reg;
  logic [ADDR_WIDTH-1:0] i_cnt_reg;
  logic [RUN_W-1:0]      run_budget_reg;

  logic [RUN_W-1:0]      cycles_run_reg;
  logic                  halted_reg;
  logic                  init_done_reg;

  logic [ADDR_WIDTH-1:0] d_w_addr_reg;
  logic [DATA_WIDTH-1:0] d_w_dat_reg;
  logic                  d_w_enb_reg;
  logic [ADDR_WIDTH-1:0] i_w_addr_reg;
  logic [DATA_WIDTH-1:0] i_w_dat_reg;
  logic                  i_w_enb_reg;

  logic [ADDR_WIDTH-1:0] d_clamped;
  logic [ADDR_WIDTH-1:0] i_clamped;
  logic [ADDR_WIDTH-1:0] phase_count;
  logic [ADDR_WIDTH-1:0] cur_byte_addr;
  logic                  cur_last;

  logic                  in_load_d;
  logic                  in_load_i;
  logic                  in_run;
  logic                  start_ok;
  logic                  accept;
  logic                  last_beat;
  logic [RUN_W:0]        cycles_inc;
  logic                  budget_hit;

  assign d_clamped = ADDR_WIDTH'(clamp_words(32'(d_count), 32'(WORD_CAP)));
  assign i_clamped = ADDR_WIDTH'(clamp_words(32'(i_count), 32'(WORD_CAP)));

  assign in_load_d = (state_reg == ST_LOAD_D);
  assign in_load_i = (state_reg == ST_LOAD_I);
  assign in_run    = (state_reg == ST_RUN);

  assign start_ok  = start && ((state_reg == ST_IDLE) || (state_reg == ST_DONE));
  assign s_ready   = in_load_d || in_load_i;
  assign accept    = s_valid && s_ready;
  assign last_beat = accept && cur_last;

  assign phase_count = in_load_d ? d_cnt_reg : i_cnt_reg;

  // One bit wider than the counter so a budget of all-ones cannot overflow
  // the compare. A zero budget is met on the first RUN cycle.
  assign cycles_inc = {1'b0, cycles_run_reg} + {{RUN_W{1'b0}}, 1'b1};
  assign budget_hit = (cycles_inc >= {1'b0, run_budget_reg});

  // Shared word index: cleared at start and at each phase boundary so the
  // program image starts at byte address 0 as well.
  word_addr_counter #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_word_addr_counter (
    .clk       (clk),
    .rst       (rst),
    .clr       (start_ok || last_beat),
    .inc       (accept),
    .count     (phase_count),
    .byte_addr (cur_byte_addr),
    .last      (cur_last)
  );

  // Next-state logic.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          if (d_clamped != '0) begin
            state_next = ST_LOAD_D;
          end else if (i_clamped != '0) begin
            state_next = ST_LOAD_I;
          end else begin
            state_next = ST_RUN;
          end
        end
      end
      ST_LOAD_D: begin
        if (last_beat) begin
          state_next = (i_cnt_reg != '0) ? ST_LOAD_I : ST_RUN;
        end
      end
      ST_LOAD_I: begin
        if (last_beat) begin
          state_next = ST_RUN;
        end
      end
      ST_RUN: begin
        if (halt || budget_hit) begin
          state_next = ST_DONE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Sequence parameters and run status.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      d_cnt_reg      <= '0;
      i_cnt_reg      <= '0;
      run_budget_reg <= '0;
      cycles_run_reg <= '0;
      halted_reg     <= 1'b0;
      init_done_reg  <= 1'b0;
    end else if (start_ok) begin
      d_cnt_reg      <= d_clamped;
      i_cnt_reg      <= i_clamped;
      run_budget_reg <= run_cycles;
      cycles_run_reg <= '0;
      halted_reg     <= 1'b0;
      // With no data image there is nothing to wait for, so the core owns
      // the data BRAM port from the outset.
      init_done_reg  <= (d_clamped == '0);
    end else begin
      if (in_load_d && last_beat) begin
        init_done_reg <= 1'b1;
      end
      if (in_run) begin
        cycles_run_reg <= cycles_inc[RUN_W-1:0];
        if (halt) begin
          halted_reg <= 1'b1;
        end
      end
    end
  end

  // Registered BRAM write ports: the pulse follows the accepted beat by one
  // clock. Address and data hold their last value between pulses.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      d_w_addr_reg <= '0;
      d_w_dat_reg  <= '0;
      d_w_enb_reg  <= 1'b0;
    end else begin
      d_w_enb_reg <= accept && in_load_d;
      if (accept && in_load_d) begin
        d_w_addr_reg <= cur_byte_addr;
        d_w_dat_reg  <= s_data;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      i_w_addr_reg <= '0;
      i_w_dat_reg  <= '0;
      i_w_enb_reg  <= 1'b0;
    end else begin
      i_w_enb_reg <= accept && in_load_i;
      if (accept && in_load_i) begin
        i_w_addr_reg <= cur_byte_addr;
        i_w_dat_reg  <= s_data;
      end
    end
  end

  assign d_w_addr = d_w_addr_reg;
  assign d_w_dat  = d_w_dat_reg;
  assign d_w_enb  = d_w_enb_reg;
  assign i_w_addr = i_w_addr_reg;
  assign i_w_dat  = i_w_dat_reg;
  assign i_w_enb  = i_w_enb_reg;

  assign d_bram_init_done = init_done_reg;
  assign pc_stall         = !in_run;
  assign i_r_enb          = in_run;
  // Register file stays readable after the run so results can be inspected.
  assign rd_enbl          = in_run || (state_reg == ST_DONE);
  assign busy             = in_load_d || in_load_i || in_run;
  assign done             = (state_reg == ST_DONE);
  assign halted           = halted_reg;
  assign cycles_run       = cycles_run_reg;

endmodule

// File: tb/tb_boot_sequencer.sv
module tb_boot_sequencer;

  localparam int DW   = 32;
  localparam int AW   = 6;
  localparam int RW   = 8;
  localparam int CAP  = 1 << (AW - 2);
  localparam int BUDGET = 2000;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] d_count = '0;
  logic [AW-1:0] i_count = '0;
  logic [RW-1:0] run_cycles = '0;
  logic          s_valid = 1'b0;
  logic [DW-1:0] s_data = '0;
  logic          s_ready;
  logic          halt = 1'b0;
  logic [AW-1:0] d_w_addr;
  logic [DW-1:0] d_w_dat;
  logic          d_w_enb;
  logic [AW-1:0] i_w_addr;
  logic [DW-1:0] i_w_dat;
  logic          i_w_enb;
  logic          d_bram_init_done;
  logic          pc_stall;
  logic          i_r_enb;
  logic          rd_enbl;
  logic          busy;
  logic          done;
  logic          halted;
  logic [RW-1:0] cycles_run;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] words [64];

  boot_sequencer #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW),
    .RUN_W(RW)
  ) dut (
    .clk(clk), .rst(rst), .start(start),
    .d_count(d_count), .i_count(i_count), .run_cycles(run_cycles),
    .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready), .halt(halt),
    .d_w_addr(d_w_addr), .d_w_dat(d_w_dat), .d_w_enb(d_w_enb),
    .i_w_addr(i_w_addr), .i_w_dat(i_w_dat), .i_w_enb(i_w_enb),
    .d_bram_init_done(d_bram_init_done), .pc_stall(pc_stall),
    .i_r_enb(i_r_enb), .rd_enbl(rd_enbl), .busy(busy), .done(done),
    .halted(halted), .cycles_run(cycles_run)
  );

  always #5 clk = ~clk;

  typedef struct {
    int dc; int ic; int rc; int halt_at; int gap; int poke;
    int exp_nd; int exp_ni; int exp_cyc; int exp_halted;
  } vec_t;

  vec_t vecs [9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: counts saturate at capacity; the core runs for the
  // budget (at least one clock) unless halt arrives no later than that.
  function automatic int clampw(input int x);
    return (x > CAP) ? CAP : x;
  endfunction

  function automatic int eff_budget(input int rc);
    return (rc == 0) ? 1 : rc;
  endfunction

  function automatic int run_len(input int rc, input int h);
    return (h > 0 && h <= eff_budget(rc)) ? h : eff_budget(rc);
  endfunction

  function automatic int halted_model(input int rc, input int h);
    return (h > 0 && h <= eff_budget(rc)) ? 1 : 0;
  endfunction

  task automatic check_reset_values(input string tag);
    check({tag, " s_ready"}, 32'(s_ready), 0);
    check({tag, " d_w_addr"}, 32'(d_w_addr), 0);
    check({tag, " d_w_dat"}, d_w_dat, 0);
    check({tag, " d_w_enb"}, 32'(d_w_enb), 0);
    check({tag, " i_w_addr"}, 32'(i_w_addr), 0);
    check({tag, " i_w_dat"}, i_w_dat, 0);
    check({tag, " i_w_enb"}, 32'(i_w_enb), 0);
    check({tag, " d_bram_init_done"}, 32'(d_bram_init_done), 0);
    check({tag, " pc_stall"}, 32'(pc_stall), 1);
    check({tag, " i_r_enb"}, 32'(i_r_enb), 0);
    check({tag, " rd_enbl"}, 32'(rd_enbl), 0);
    check({tag, " busy"}, 32'(busy), 0);
    check({tag, " done"}, 32'(done), 0);
    check({tag, " halted"}, 32'(halted), 0);
    check({tag, " cycles_run"}, 32'(cycles_run), 0);
  endtask

  // Runs one full sequence; inputs are driven just after the falling edge and
  // outputs observed at the falling edge, before driving.
  task automatic run_seq(input string tag, input int dc, input int ic, input int rc,
                         input int halt_at, input int gap, input int poke,
                         input int exp_nd, input int exp_ni, input int exp_cyc,
                         input int exp_halted);
    logic [AW-1:0] d_addr_q[$];
    logic [DW-1:0] d_dat_q[$];
    logic [AW-1:0] i_addr_q[$];
    logic [DW-1:0] i_dat_q[$];
    int idx = 0;
    int run_clk = 0;
    int last_run_cyc = -10;
    int first_done_cyc = -1;
    int ready_cycles = 0;
    int run_sig_bad = 0;
    logic init_at_run = 1'b0;
    logic finished = 1'b0;
    logic poked_i = 1'b0;
    logic poked_r = 1'b0;

    for (int k = 0; k < 64; k++) words[k] = $urandom;

    d_count = AW'(dc);
    i_count = AW'(ic);
    run_cycles = RW'(rc);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    // Counts are sampled only at start; later values must not matter.
    d_count = AW'($urandom);
    i_count = AW'($urandom);
    run_cycles = RW'($urandom);

    for (int cyc = 0; cyc < BUDGET && !finished; cyc++) begin
      if (d_w_enb) begin d_addr_q.push_back(d_w_addr); d_dat_q.push_back(d_w_dat); end
      if (i_w_enb) begin i_addr_q.push_back(i_w_addr); i_dat_q.push_back(i_w_dat); end
      if (s_ready) ready_cycles++;
      if (!pc_stall) begin
        run_clk++;
        if (run_clk == 1) init_at_run = d_bram_init_done;
        last_run_cyc = cyc;
        if (!i_r_enb || !rd_enbl || !busy) run_sig_bad++;
      end
      if (done) begin
        first_done_cyc = cyc;
        finished = 1'b1;
      end else begin
        start = 1'b0;
        if (!pc_stall) halt = (halt_at != 0 && run_clk == halt_at);
        else halt = (gap == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
        if (poke != 0 && s_ready && d_bram_init_done && !poked_i) begin
          start = 1'b1; poked_i = 1'b1;
        end
        if (poke != 0 && !pc_stall && !poked_r) begin
          start = 1'b1; poked_r = 1'b1;
        end
        case (gap)
          0: s_valid = 1'b1;
          1: s_valid = (cyc % 2 == 0);
          default: s_valid = ($urandom_range(0, 3) != 0);
        endcase
        s_data = words[idx];
        if (s_valid && s_ready) idx++;
        @(negedge clk);
      end
    end
    start = 1'b0;
    s_valid = 1'b0;
    halt = 1'b0;

    check({tag, " sequence_reached_done"}, 32'(finished), 1);
    check({tag, " d_writes"}, d_addr_q.size(), exp_nd);
    check({tag, " i_writes"}, i_addr_q.size(), exp_ni);
    for (int k = 0; k < d_addr_q.size() && k < exp_nd; k++) begin
      check($sformatf("%s d_addr[%0d]", tag, k), 32'(d_addr_q[k]), 32'(4 * k));
      check($sformatf("%s d_dat[%0d]", tag, k), d_dat_q[k], words[k]);
    end
    for (int k = 0; k < i_addr_q.size() && k < exp_ni; k++) begin
      check($sformatf("%s i_addr[%0d]", tag, k), 32'(i_addr_q[k]), 32'(4 * k));
      check($sformatf("%s i_dat[%0d]", tag, k), i_dat_q[k], words[exp_nd + k]);
    end
    check({tag, " cycles_run"}, 32'(cycles_run), exp_cyc);
    check({tag, " halted"}, 32'(halted), exp_halted);
    check({tag, " stall_low_clocks"}, run_clk, exp_cyc);
    check({tag, " done_follows_run"}, first_done_cyc, last_run_cyc + 1);
    check({tag, " init_done_at_run"}, 32'(init_at_run), 1);
    check({tag, " run_enables"}, run_sig_bad, 0);
    check({tag, " end pc_stall"}, 32'(pc_stall), 1);
    check({tag, " end i_r_enb"}, 32'(i_r_enb), 0);
    check({tag, " end rd_enbl"}, 32'(rd_enbl), 1);
    check({tag, " end busy"}, 32'(busy), 0);
    check({tag, " end s_ready"}, 32'(s_ready), 0);
    check({tag, " end d_bram_init_done"}, 32'(d_bram_init_done), 1);
    if (gap == 0) check({tag, " load_clocks"}, ready_cycles, exp_nd + exp_ni);
    $display("seq %s: dc=%0d ic=%0d rc=%0d halt_at=%0d gap=%0d -> dw=%0d iw=%0d cycles_run=%0d halted=%0d",
             tag, dc, ic, rc, halt_at, gap, d_addr_q.size(), i_addr_q.size(), cycles_run, halted);
  endtask

  initial begin
    //              dc  ic  rc  halt gap poke nd  ni  cyc halted
    vecs[0] = '{    3,  7,   7,  0,  0,  0,   3,  7,  7,  0};
    vecs[1] = '{    3,  7,   7,  0,  1,  0,   3,  7,  7,  0};
    vecs[2] = '{    0,  2,   4,  0,  0,  0,   0,  2,  4,  0};
    vecs[3] = '{    2,  1, 100,  5,  0,  0,   2,  1,  5,  1};
    vecs[4] = '{    0,  0,   0,  0,  0,  0,   0,  0,  1,  0};
    vecs[5] = '{    1,  1,   3,  3,  0,  0,   1,  1,  3,  1};
    vecs[6] = '{   20, 17,   2,  0,  0,  0,  16, 16,  2,  0};
    vecs[7] = '{    1,  0,   1,  1,  1,  0,   1,  0,  1,  1};
    vecs[8] = '{    4,  5,   6,  0,  0,  1,   4,  5,  6,  0};

    rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_reset_values("reset");
    rst = 1'b1;
    @(negedge clk);

    for (int v = 0; v < 9; v++) begin
      run_seq($sformatf("vec%0d", v), vecs[v].dc, vecs[v].ic, vecs[v].rc,
              vecs[v].halt_at, vecs[v].gap, vecs[v].poke,
              vecs[v].exp_nd, vecs[v].exp_ni, vecs[v].exp_cyc, vecs[v].exp_halted);
    end

    // Reset in the middle of the data load, after two beats are written.
    begin
      int wr_seen = 0;
      int idx = 0;
      for (int k = 0; k < 64; k++) words[k] = $urandom;
      d_count = AW'(3);
      i_count = AW'(2);
      run_cycles = RW'(3);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int cyc = 0; cyc < 100 && wr_seen < 2; cyc++) begin
        if (d_w_enb) wr_seen++;
        if (wr_seen < 2) begin
          s_valid = 1'b1;
          s_data = words[idx];
          if (s_ready) idx++;
          @(negedge clk);
        end
      end
      s_valid = 1'b0;
      check("midrst writes_before_reset", wr_seen, 2);
      #2 rst = 1'b0;
      #1;
      check_reset_values("midrst");
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      $display("seq midrst: reset applied after %0d data writes", wr_seen);
    end
    run_seq("after_rst", 3, 2, 3, 0, 0, 0, 3, 2, 3, 0);

    // Randomized sequences against the reference model.
    for (int r = 0; r < 25; r++) begin
      int dc = $urandom_range(0, 20);
      int ic = $urandom_range(0, 20);
      int rc = $urandom_range(0, 25);
      int h  = ($urandom_range(0, 1) != 0) ? $urandom_range(1, rc + 3) : 0;
      run_seq($sformatf("rnd%0d", r), dc, ic, rc, h, 2, int'($urandom_range(0, 1)),
              clampw(dc), clampw(ic), run_len(rc, h), halted_model(rc, h));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
